// File: rtl/lane_game_engine.sv
// rtl/lane_game_engine.sv - obstacle-lane game core with rotating lanes, player, lives, score and pixel query
module lane_game_engine #(
    parameter int COLS  = 20,
    parameter int LANES = 13,
    parameter int LIVES = 3,
    parameter int SPD_W = 3,
    localparam int COL_W = $clog2(COLS),
    localparam int ROW_W = $clog2(LANES + 2),
    localparam int LIV_W = $clog2(LIVES + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             lane_tick,
    input  logic             move_tick,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             cfg_we,
    input  logic [ROW_W-1:0] cfg_lane,
    input  logic [COLS-1:0]  cfg_pattern,
    input  logic             cfg_dir,
    input  logic [SPD_W-1:0] cfg_period,
    input  logic [COL_W-1:0] px_col,
    input  logic [ROW_W-1:0] px_row,
    output logic             px_obst,
    output logic             px_player,
    output logic [COL_W-1:0] player_col,
    output logic [ROW_W-1:0] player_row,
    output logic [7:0]       score,
    output logic [LIV_W-1:0] lives,
    output logic [2:0]       state,
    output logic             hit_pulse,
    output logic             win_pulse
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PLAY = 3'd1,
        S_HIT  = 3'd2,
        S_WIN  = 3'd3,
        S_OVER = 3'd4
    } state_t;

    localparam logic [COL_W-1:0] START_COL  = COL_W'(COLS / 2);
    localparam logic [ROW_W-1:0] START_ROW  = ROW_W'(LANES + 1);
    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(COLS - 1);
    localparam logic [LIV_W-1:0] FULL_LIVES = LIV_W'(LIVES);

    state_t cur, nxt;

    logic [COLS-1:0]  pattern [1:LANES];
    logic             dir     [1:LANES];
    logic [SPD_W-1:0] period  [1:LANES];
    logic [SPD_W-1:0] cnt     [1:LANES];

    logic             start_q;
    logic             start_rise;
    logic             collide;
    logic             frozen;
    logic             col_ok;
    logic             px_obst_d;
    logic             px_player_d;
    logic [ROW_W-1:0] move_row;
    logic [COL_W-1:0] move_col;

    assign state      = cur;
    assign start_rise = start & ~start_q;
    assign frozen     = (cur == S_IDLE) || (cur == S_OVER);
    // widened compare keeps the range check correct even when COLS is a power of two
    assign col_ok     = ({1'b0, px_col} < (COL_W + 1)'(COLS));

    function automatic logic [COLS-1:0] rotate(input logic [COLS-1:0] p, input logic d);
        return d ? {p[COLS-2:0], p[COLS-1]} : {p[0], p[COLS-1:1]};
    endfunction

    always_comb begin
        collide   = 1'b0;
        px_obst_d = 1'b0;
        for (int l = 1; l <= LANES; l++) begin
            if (player_row == ROW_W'(l)) collide = pattern[l][player_col];
            if (col_ok && px_row == ROW_W'(l)) px_obst_d = pattern[l][px_col];
        end
        px_player_d = col_ok && (px_row == player_row) && (px_col == player_col);
    end

    always_comb begin
        move_row = player_row;
        move_col = player_col;
        if (move_tick && $onehot({btn_up, btn_down, btn_left, btn_right})) begin
            if (btn_up && player_row != '0)           move_row = player_row - 1'b1;
            if (btn_down && player_row != START_ROW)  move_row = player_row + 1'b1;
            if (btn_left && player_col != '0)         move_col = player_col - 1'b1;
            if (btn_right && player_col != LAST_COL)  move_col = player_col + 1'b1;
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE, S_OVER: if (start_rise) nxt = S_PLAY;
            S_PLAY: begin
                if (collide)                nxt = S_HIT;
                else if (player_row == '0)  nxt = S_WIN;
            end
            S_HIT:   nxt = (lives == LIV_W'(1)) ? S_OVER : S_PLAY;
            S_WIN:   nxt = S_PLAY;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) cur <= S_IDLE;
        else          cur <= nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int l = 1; l <= LANES; l++) begin
                pattern[l] <= '0;
                dir[l]     <= 1'b0;
                period[l]  <= '0;
                cnt[l]     <= '0;
            end
            player_col <= START_COL;
            player_row <= START_ROW;
            lives      <= FULL_LIVES;
            score      <= '0;
            px_obst    <= 1'b0;
            px_player  <= 1'b0;
            hit_pulse  <= 1'b0;
            win_pulse  <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            start_q   <= start;
            px_obst   <= px_obst_d;
            px_player <= px_player_d;
            hit_pulse <= (nxt == S_HIT);
            win_pulse <= (nxt == S_WIN);
            for (int l = 1; l <= LANES; l++) begin
                if (frozen) begin
                    if (cfg_we && cfg_lane == ROW_W'(l)) begin
                        pattern[l] <= cfg_pattern;
                        dir[l]     <= cfg_dir;
                        period[l]  <= cfg_period;
                        cnt[l]     <= '0;
                    end
                end else if (lane_tick) begin
                    if (cnt[l] == period[l]) begin
                        cnt[l]     <= '0;
                        pattern[l] <= rotate(pattern[l], dir[l]);
                    end else begin
                        cnt[l] <= cnt[l] + 1'b1;
                    end
                end
            end
            case (cur)
                S_IDLE, S_OVER: begin
                    if (start_rise) begin
                        lives      <= FULL_LIVES;
                        score      <= '0;
                        player_col <= START_COL;
                        player_row <= START_ROW;
                    end
                end
                S_PLAY: begin
                    // a move never lands on the edge that leaves PLAY
                    if (!collide && player_row != '0) begin
                        player_row <= move_row;
                        player_col <= move_col;
                    end
                end
                S_HIT: begin
                    lives      <= lives - 1'b1;
                    player_col <= START_COL;
                    player_row <= START_ROW;
                end
                S_WIN: begin
                    if (score != 8'hFF) score <= score + 8'd1;
                    player_col <= START_COL;
                    player_row <= START_ROW;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lane_game_engine.sv
// tb/tb_lane_game_engine.sv - scoreboard bench for lane_game_engine
module tb_lane_game_engine;

    localparam int COLS  = 20;
    localparam int LANES = 13;
    localparam int LIVES = 3;
    localparam int SPD_W = 3;
    localparam int COL_W = 5;
    localparam int ROW_W = 4;
    localparam int LIV_W = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             lane_tick = 1'b0;
    logic             move_tick = 1'b0;
    logic             btn_up = 1'b0;
    logic             btn_down = 1'b0;
    logic             btn_left = 1'b0;
    logic             btn_right = 1'b0;
    logic             cfg_we = 1'b0;
    logic [ROW_W-1:0] cfg_lane = '0;
    logic [COLS-1:0]  cfg_pattern = '0;
    logic             cfg_dir = 1'b0;
    logic [SPD_W-1:0] cfg_period = '0;
    logic [COL_W-1:0] px_col = '0;
    logic [ROW_W-1:0] px_row = '0;
    logic             px_obst;
    logic             px_player;
    logic [COL_W-1:0] player_col;
    logic [ROW_W-1:0] player_row;
    logic [7:0]       score;
    logic [LIV_W-1:0] lives;
    logic [2:0]       state;
    logic             hit_pulse;
    logic             win_pulse;

    lane_game_engine #(.COLS(COLS), .LANES(LANES), .LIVES(LIVES), .SPD_W(SPD_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .lane_tick(lane_tick), .move_tick(move_tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .cfg_we(cfg_we), .cfg_lane(cfg_lane), .cfg_pattern(cfg_pattern), .cfg_dir(cfg_dir),
        .cfg_period(cfg_period), .px_col(px_col), .px_row(px_row), .px_obst(px_obst),
        .px_player(px_player), .player_col(player_col), .player_row(player_row), .score(score),
        .lives(lives), .state(state), .hit_pulse(hit_pulse), .win_pulse(win_pulse)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sbq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic pop(input logic [31:0] obs);
        exp_t e;
        if (sbq.size() == 0) begin
            check("sb_underflow", 32'(sbq.size()), 32'd1);
        end else begin
            e = sbq.pop_front();
            check(e.tag, obs, e.val);
        end
    endtask

    task automatic expect_core(input int st, input int r, input int c, input int l, input int s);
        push("state", st);
        push("row", r);
        push("col", c);
        push("lives", l);
        push("score", s);
    endtask

    task automatic pop_core();
        pop(state);
        pop(player_row);
        pop(player_col);
        pop(lives);
        pop(score);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic read_lane(input int lane, output logic [COLS-1:0] pat);
        pat = '0;
        px_row = ROW_W'(lane);
        for (int c = 0; c < COLS; c++) begin
            px_col = COL_W'(c);
            cyc();
            pat[c] = px_obst;
        end
    endtask

    task automatic lane_expect(input int lane, input logic [COLS-1:0] exp);
        logic [COLS-1:0] got;
        push($sformatf("pat%0d", lane), 32'(exp));
        read_lane(lane, got);
        pop(32'(got));
    endtask

    task automatic cfg_write(input int lane, input logic [COLS-1:0] pat, input logic d, input int per);
        cfg_we = 1'b1;
        cfg_lane = ROW_W'(lane);
        cfg_pattern = pat;
        cfg_dir = d;
        cfg_period = SPD_W'(per);
        cyc();
        cfg_we = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        expect_core(0, 14, 10, 3, 0);
        push("px_obst", 0); push("px_player", 0); push("hit", 0); push("win", 0);
        cyc(); cyc();
        pop_core(); pop(px_obst); pop(px_player); pop(hit_pulse); pop(win_pulse);
        reset_n = 1'b1;

        px_row = 14; px_col = 10;
        push("q_player", 1); push("q_obst", 0);
        cyc();
        pop(px_player); pop(px_obst);
        px_col = 11;
        push("q_player_off", 0);
        cyc();
        pop(px_player);

        // rotation: lane 13, dir up, period 1
        cfg_write(13, 20'h00001, 1'b1, 1);
        lane_expect(13, 20'h00001);
        start = 1'b1;
        expect_core(1, 14, 10, 3, 0);
        cyc();
        pop_core();
        start = 1'b0;
        lane_tick = 1'b1; repeat (4) cyc(); lane_tick = 1'b0;
        lane_expect(13, 20'h00004);
        lane_tick = 1'b1; repeat (34) cyc(); lane_tick = 1'b0;
        lane_expect(13, 20'h80000);
        lane_tick = 1'b1; repeat (2) cyc(); lane_tick = 1'b0;
        lane_expect(13, 20'h00001);
        start = 1'b1;
        push("start_in_play", 1);
        cyc();
        pop(state);
        start = 1'b0;

        // goal crossing and move rules
        reset_n = 1'b0; cyc(); reset_n = 1'b1;
        start = 1'b1;
        expect_core(1, 14, 10, 3, 0);
        cyc(); pop_core();
        start = 1'b0;
        btn_up = 1'b1; btn_left = 1'b1; move_tick = 1'b1;
        expect_core(1, 14, 10, 3, 0);
        cyc(); pop_core();
        btn_left = 1'b0;
        expect_core(1, 0, 10, 3, 0);
        repeat (14) cyc();
        pop_core();
        btn_up = 1'b0; btn_down = 1'b1;
        push("win_state", 3); push("win_row", 0); push("win_pulse", 1); push("win_score", 0);
        cyc();
        pop(state); pop(player_row); pop(win_pulse); pop(score);
        expect_core(1, 14, 10, 3, 1); push("win_pulse_off", 0);
        cyc();
        pop_core(); pop(win_pulse);
        expect_core(1, 14, 10, 3, 1);
        cyc(); pop_core();
        btn_down = 1'b0; btn_left = 1'b1;
        expect_core(1, 14, 0, 3, 1);
        repeat (12) cyc();
        pop_core();
        btn_left = 1'b0; btn_right = 1'b1;
        expect_core(1, 14, 19, 3, 1);
        repeat (21) cyc();
        pop_core();
        btn_right = 1'b0; move_tick = 1'b0;

        // collisions down to game over
        reset_n = 1'b0; cyc(); reset_n = 1'b1;
        cfg_write(13, 20'h00400, 1'b1, 0);
        start = 1'b1; cyc(); start = 1'b0;
        cfg_write(13, 20'hFFFFF, 1'b0, 2);
        lane_expect(13, 20'h00400);
        for (int i = 0; i < 3; i++) begin
            btn_up = 1'b1; move_tick = 1'b1;
            expect_core(1, 13, 10, 3 - i, 0);
            cyc(); pop_core();
            btn_up = 1'b0; move_tick = 1'b0;
            push("hit_state", 2); push("hit_pulse", 1); push("hit_lives", 3 - i);
            cyc();
            pop(state); pop(hit_pulse); pop(lives);
            expect_core((i == 2) ? 4 : 1, 14, 10, 2 - i, 0); push("hit_pulse_off", 0);
            cyc();
            pop_core(); pop(hit_pulse);
        end
        lane_tick = 1'b1; repeat (3) cyc(); lane_tick = 1'b0;
        lane_expect(13, 20'h00400);
        cfg_write(14, 20'hFFFFF, 1'b1, 0);
        cfg_write(12, 20'h00003, 1'b0, 0);
        lane_expect(12, 20'h00003);
        lane_expect(13, 20'h00400);
        start = 1'b1;
        expect_core(1, 14, 10, 3, 0);
        cyc(); pop_core();
        start = 1'b0;
        lane_tick = 1'b1; cyc(); lane_tick = 1'b0;
        lane_expect(12, 20'h80001);
        lane_expect(13, 20'h00800);

        // reset mid-play with ticks
        btn_up = 1'b1; move_tick = 1'b1; lane_tick = 1'b1; reset_n = 1'b0;
        expect_core(0, 14, 10, 3, 0);
        push("rst_hit", 0); push("rst_win", 0); push("rst_obst", 0); push("rst_player", 0);
        cyc();
        pop_core(); pop(hit_pulse); pop(win_pulse); pop(px_obst); pop(px_player);
        reset_n = 1'b1; btn_up = 1'b0; move_tick = 1'b0; lane_tick = 1'b0;
        lane_expect(12, 20'h00000);
        lane_expect(13, 20'h00000);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
